// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder / instruction-memory / lookup-table bundle for pc_sequencer
interface pc_sequencer_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          start;
  logic          halt_req;
  logic          stall;
  logic          branch_en;
  logic          branch_cond;
  logic [7:0]    lut_idx;
  logic [7:0]    lut_addr;
  logic [D-1:0]  lut_target;
  logic [D-1:0]  pc;
  logic          fetch_valid;
  logic          running;
  logic          done;
  logic [CW-1:0] branch_cnt;

  modport master (
    output start, halt_req, stall, branch_en, branch_cond, lut_idx, lut_target,
    input  lut_addr, pc, fetch_valid, running, done, branch_cnt
  );

  modport slave (
    input  start, halt_req, stall, branch_en, branch_cond, lut_idx, lut_target,
    output lut_addr, pc, fetch_valid, running, done, branch_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with table-resolved relative branches
module pc_sequencer #(
  parameter int          D        = 12,
  parameter int unsigned START_PC = 0,
  parameter int          CW       = 16
) (
  input  logic           Clk,
  input  logic           Reset_n,
  pc_sequencer_if.slave  bus
);
  localparam logic [D-1:0] START_VAL = D'(START_PC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BR_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_nx;
  logic [D-1:0]  r_pc, w_pc_nx;
  logic [7:0]    r_lut_addr, w_lut_addr_nx;
  logic          r_done, w_done_nx;
  logic [CW-1:0] r_branch_cnt, w_branch_cnt_nx;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= START_VAL;
      r_lut_addr   <= 8'd0;
      r_done       <= 1'b0;
      r_branch_cnt <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_lut_addr   <= w_lut_addr_nx;
      r_done       <= w_done_nx;
      r_branch_cnt <= w_branch_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_lut_addr_nx   = r_lut_addr;
    w_done_nx       = r_done;
    w_branch_cnt_nx = r_branch_cnt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nx      = S_RUN;
          w_pc_nx         = START_VAL;
          w_done_nx       = 1'b0;
          w_branch_cnt_nx = '0;
        end
      end
      S_RUN: begin
        if (bus.halt_req) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end else if (bus.stall) begin
          w_state_nx = S_RUN;
        end else if (bus.branch_en && bus.branch_cond) begin
          w_state_nx    = S_BR_WAIT;
          w_lut_addr_nx = bus.lut_idx;
          if (r_branch_cnt != {CW{1'b1}})
            w_branch_cnt_nx = r_branch_cnt + 1'b1;
        end else begin
          w_pc_nx = r_pc + D'(1);
        end
      end
      S_BR_WAIT: begin
        // A zero offset would branch to itself forever, so it ends the program instead.
        if (bus.halt_req || (!bus.stall && bus.lut_target == '0)) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end else if (!bus.stall) begin
          w_state_nx = S_RUN;
          w_pc_nx    = r_pc + bus.lut_target;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.pc          = r_pc;
  assign bus.lut_addr    = r_lut_addr;
  assign bus.done        = r_done;
  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.fetch_valid = (r_state == S_RUN) && !bus.stall;
  assign bus.running     = (r_state == S_RUN) || (r_state == S_BR_WAIT);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed bench for pc_sequencer with a behavioural model
module tb_pc_sequencer;
  localparam int D  = 12;
  localparam int CW = 4;
  localparam int M  = 1 << D;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  pc_sequencer_if #(.D(D), .CW(CW)) bus();
  pc_sequencer #(.D(D), .START_PC(0), .CW(CW)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));

  always #5 Clk = ~Clk;

  function automatic int lut_val(input logic [7:0] idx);
    case (idx)
      8'd0:    return -5;
      8'd1:    return 20;
      8'd2:    return -1;
      default: return 0;
    endcase
  endfunction

  assign bus.lut_target = D'(lut_val(bus.lut_addr));

  // mode: 0 idle, 1 running, 2 waiting on table, 3 finished
  int m_mode = 0;
  int m_pc = 0;
  int m_laddr = 0;
  int m_done = 0;
  int m_cnt = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_mode = 0; m_pc = 0; m_laddr = 0; m_done = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0, 3: if (bus.start) begin m_mode = 1; m_pc = 0; m_done = 0; m_cnt = 0; end
        1: begin
          if (bus.halt_req) begin m_mode = 3; m_done = 1; end
          else if (bus.stall) ;
          else if (bus.branch_en && bus.branch_cond) begin
            m_mode = 2; m_laddr = bus.lut_idx;
            m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
          end else m_pc = (m_pc + 1) % M;
        end
        2: begin
          if (bus.halt_req) begin m_mode = 3; m_done = 1; end
          else if (bus.stall) ;
          else if (lut_val(8'(m_laddr)) == 0) begin m_mode = 3; m_done = 1; end
          else begin m_pc = (m_pc + lut_val(8'(m_laddr)) + M) % M; m_mode = 1; end
        end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    chk("pc", int'(bus.pc), m_pc);
    chk("lut_addr", int'(bus.lut_addr), m_laddr);
    chk("done", int'(bus.done), m_done);
    chk("branch_cnt", int'(bus.branch_cnt), m_cnt);
    chk("running", int'(bus.running), int'(m_mode == 1 || m_mode == 2));
    chk("fetch_valid", int'(bus.fetch_valid), int'(m_mode == 1 && !bus.stall));
  end

  task automatic drive(input logic st, input logic hr, input logic sl, input logic be,
                       input logic bc, input logic [7:0] idx);
    bus.start = st; bus.halt_req = hr; bus.stall = sl;
    bus.branch_en = be; bus.branch_cond = bc; bus.lut_idx = idx;
    @(posedge Clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 8'd0);
  endtask

  task automatic branch(input logic [7:0] idx);
    drive(0, 0, 0, 1, 1, idx);
  endtask

  initial begin
    bus.start = 0; bus.halt_req = 0; bus.stall = 0;
    bus.branch_en = 0; bus.branch_cond = 0; bus.lut_idx = 8'd0;
    #1;
    chk("reset pc", int'(bus.pc), 0);
    chk("reset running", int'(bus.running), 0);
    chk("reset fetch_valid", int'(bus.fetch_valid), 0);
    chk("reset done", int'(bus.done), 0);
    #2 Reset_n = 1'b1;

    drive(1, 0, 0, 0, 0, 8'd0);
    chk("start pc", int'(bus.pc), 0);
    for (int i = 1; i <= 7; i++) begin
      idle(1);
      chk("seq pc", int'(bus.pc), i);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 8'd0);
      chk("stall pc", int'(bus.pc), 7);
    end
    idle(1);
    chk("after stall pc", int'(bus.pc), 8);
    idle(2);
    branch(8'd0);
    chk("br wait pc", int'(bus.pc), 10);
    chk("br lut_addr", int'(bus.lut_addr), 0);
    chk("br cnt", int'(bus.branch_cnt), 1);
    idle(1);
    chk("br target", int'(bus.pc), 5);
    branch(8'd0); idle(1);
    chk("br to zero", int'(bus.pc), 0);
    idle(4);
    branch(8'd0); idle(1);
    chk("br negative", int'(bus.pc), 'hFFF);
    chk("br cnt3", int'(bus.branch_cnt), 3);
    idle(1);
    chk("wrap fff", int'(bus.pc), 0);
    idle(1);
    branch(8'd0); idle(1);
    chk("br to ffc", int'(bus.pc), 'hFFC);
    idle(2);
    chk("seq ffe", int'(bus.pc), 'hFFE);
    idle(1);
    chk("seq fff", int'(bus.pc), 'hFFF);
    idle(1);
    chk("wrap 000", int'(bus.pc), 0);
    idle(3);
    branch(8'd1);
    chk("idx1 lut_addr", int'(bus.lut_addr), 1);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 0, 8'd2);
      chk("br stall pc", int'(bus.pc), 3);
      chk("br stall running", int'(bus.running), 1);
    end
    idle(1);
    chk("br stalled target", int'(bus.pc), 23);
    branch(8'd9); idle(1);
    chk("self loop done", int'(bus.done), 1);
    chk("self loop pc", int'(bus.pc), 23);
    chk("self loop running", int'(bus.running), 0);
    drive(0, 1, 1, 1, 1, 8'd0);
    drive(0, 0, 0, 1, 1, 8'd1);
    chk("done frozen pc", int'(bus.pc), 23);
    chk("done lut_addr", int'(bus.lut_addr), 9);
    chk("done cnt", int'(bus.branch_cnt), 6);
    drive(1, 0, 0, 0, 0, 8'd0);
    chk("restart pc", int'(bus.pc), 0);
    chk("restart done", int'(bus.done), 0);
    chk("restart cnt", int'(bus.branch_cnt), 0);
    idle(12);
    drive(0, 1, 0, 0, 0, 8'd0);
    chk("halt done", int'(bus.done), 1);
    chk("halt pc", int'(bus.pc), 12);
    drive(1, 0, 0, 0, 0, 8'd0);
    idle(1);
    drive(1, 0, 0, 0, 0, 8'd0);
    chk("start in run ignored", int'(bus.pc), 2);
    branch(8'd1);
    #1 Reset_n = 1'b0;
    #1;
    chk("async rst pc", int'(bus.pc), 0);
    chk("async rst running", int'(bus.running), 0);
    chk("async rst lut_addr", int'(bus.lut_addr), 0);
    chk("async rst cnt", int'(bus.branch_cnt), 0);
    #2 Reset_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] idx;
      idx = 8'($urandom_range(0, 3));
      if (idx == 8'd3) idx = 8'd9;
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 2) != 0), idx);
    end

    @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
